// File: rtl/ser_word_arbiter.sv
// Round-robin arbiter sharing one 32-to-8 byte serializer among NUM_REQ word requesters.
// Optional `SER_WORD_CNT_EN adds a saturating 16-bit launch counter output word_cnt.
module ser_word_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    div_8_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_out,
    output logic [31:0]             ser_word,
    output logic                    byte_valid,
    output logic [1:0]              byte_idx,
    output logic [ID_W-1:0]         byte_src,
    output logic                    busy
`ifdef SER_WORD_CNT_EN
    ,
    output logic [15:0]             word_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StLaunch, StShift} state_e;

    localparam logic [ID_W:0]   NumReqW = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LastReq = ID_W'(NUM_REQ - 1);

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic            found;
    logic            arb;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    assign arb = !rst && enable && found &&
                 (state_q == StIdle || (state_q == StShift && byte_idx == 2'd3));

    always_comb begin
        req_ready = '0;
        if (arb) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            tx_out     <= 1'b0;
            ser_word   <= '0;
            byte_valid <= 1'b0;
            byte_idx   <= '0;
            byte_src   <= '0;
        end else begin
            if (arb) begin
                ser_word   <= req_data[32*grant_idx +: 32];
                byte_src   <= grant_idx;
                rr_ptr_q   <= (grant_idx == LastReq) ? '0 : grant_idx + 1'b1;
                state_q    <= StLaunch;
                tx_out     <= 1'b1;
                byte_valid <= 1'b0;
                byte_idx   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tx_out     <= 1'b0;
                        byte_valid <= 1'b0;
                    end
                    StLaunch: begin
                        tx_out     <= 1'b0;
                        byte_valid <= 1'b1;
                        byte_idx   <= '0;
                        state_q    <= StShift;
                    end
                    StShift: begin
                        if (byte_idx == 2'd3) begin
                            byte_valid <= 1'b0;
                            byte_idx   <= '0;
                            state_q    <= StIdle;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef SER_WORD_CNT_EN
    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (tx_out && word_cnt != 16'hFFFF) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule
